// File: rtl/tft_pkg.sv
// Shared types and helpers for the TFT pixel writer: FSM encoding, the default
// Memory Write command byte and RGB888 -> RGB565 packing.
package tft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_PIX_WAIT,
    ST_BYTE_HI,
    ST_BYTE_LO,
    ST_DONE
  } tft_state_e;

  localparam logic [7:0] CMD_MEM_WRITE_DEFAULT = 8'h2C;

  // Truncating conversion: the low bits of each channel are simply dropped.
  function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    logic [15:0] r16, g16, b16;
    r16 = {8'd0, r};
    g16 = {8'd0, g};
    b16 = {8'd0, b};
    return ((r16 >> 3) << 11) | ((g16 >> 2) << 5) | (b16 >> 3);
  endfunction

endpackage

// File: rtl/tft_wr_strobe_gen.sv
// Generates one 8080 write strobe per byte: wr_n low for WR_LOW_CYCLES, then high
// for WR_HIGH_CYCLES; byte_done flags the last high cycle so the next byte can chain.
module tft_wr_strobe_gen #(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic byte_start,
  output logic wr_n,
  output logic byte_done
);

  logic       active;
  logic [7:0] phase_cnt;

  // Asserted during the final high cycle so a back-to-back byte_start falls
  // wr_n exactly when the high phase ends.
  assign byte_done = active && wr_n && (phase_cnt == 8'(WR_HIGH_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_n      <= 1'b1;
      active    <= 1'b0;
      phase_cnt <= 8'd0;
    end else if (byte_start) begin
      wr_n      <= 1'b0;
      active    <= 1'b1;
      phase_cnt <= 8'd0;
    end else if (active) begin
      if (!wr_n) begin
        if (phase_cnt == 8'(WR_LOW_CYCLES - 1)) begin
          wr_n      <= 1'b1;
          phase_cnt <= 8'd0;
        end else begin
          phase_cnt <= phase_cnt + 8'd1;
        end
      end else if (phase_cnt == 8'(WR_HIGH_CYCLES - 1)) begin
        active    <= 1'b0;
        phase_cnt <= 8'd0;
      end else begin
        phase_cnt <= phase_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/tft_pixel_writer.sv
// Pulls RGB888 pixels over rdy/stb, converts to RGB565 and writes one frame
// (Memory Write command + W*H pixels, high byte first) onto an 8-bit 8080 bus.
module tft_pixel_writer
  import tft_pkg::*;
#(
  parameter int         WR_LOW_CYCLES  = 2,
  parameter int         WR_HIGH_CYCLES = 2,
  parameter logic [7:0] CMD_MEM_WRITE  = CMD_MEM_WRITE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_start,
  input  logic [11:0] i_image_width,
  input  logic [11:0] i_image_height,
  output logic        o_busy,
  output logic        o_frame_done,
  input  logic        i_pixel_rdy,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  output logic        o_pixel_stb,
  output logic        o_tft_cs_n,
  output logic        o_tft_dc,
  output logic        o_tft_wr_n,
  output logic [7:0]  o_tft_data,
  output tft_state_e  o_dbg_state
);

  // Handshake: a pixel is taken when i_pixel_rdy is high in PIX_WAIT; o_pixel_stb
  // pulses the following cycle. Upstream drops rdy one cycle late, so rdy is
  // ignored while stb is high.

  tft_state_e  state;
  logic [23:0] frame_total;
  logic [23:0] pix_count;
  logic [23:0] req_total;
  logic [15:0] in_word;
  logic [7:0]  pix_lo;
  logic        accept;
  logic        byte_start;
  logic        byte_done;

  assign req_total   = i_image_width * i_image_height;
  assign in_word     = rgb565(i_red, i_green, i_blue);
  assign accept      = (state == ST_PIX_WAIT) && i_enable && i_pixel_rdy && !o_pixel_stb;
  assign byte_start  = ((state == ST_CS_SETUP) && i_enable) || accept ||
                       ((state == ST_BYTE_HI) && byte_done && i_enable);
  assign o_dbg_state = state;

  tft_wr_strobe_gen #(
    .WR_LOW_CYCLES (WR_LOW_CYCLES),
    .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
  ) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .byte_start(byte_start),
    .wr_n      (o_tft_wr_n),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      o_tft_cs_n   <= 1'b1;
      o_tft_dc     <= 1'b1;
      o_tft_data   <= 8'd0;
      o_pixel_stb  <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      frame_total  <= 24'd0;
      pix_count    <= 24'd0;
      pix_lo       <= 8'd0;
    end else begin
      o_pixel_stb  <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_enable && i_start) begin
            frame_total <= req_total;
            pix_count   <= 24'd0;
            o_busy      <= 1'b1;
            if (req_total == 24'd0) begin
              state <= ST_DONE;
            end else begin
              o_tft_cs_n <= 1'b0;
              state      <= ST_CS_SETUP;
            end
          end
        end
        ST_CS_SETUP: begin
          if (i_enable) begin
            o_tft_dc   <= 1'b0;
            o_tft_data <= CMD_MEM_WRITE;
            state      <= ST_CMD;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_CMD: begin
          if (byte_done) begin
            o_tft_dc <= 1'b1;
            state    <= i_enable ? ST_PIX_WAIT : ST_DONE;
          end
        end
        ST_PIX_WAIT: begin
          if (!i_enable) begin
            state <= ST_DONE;
          end else if (accept) begin
            o_tft_data  <= in_word[15:8];
            pix_lo      <= in_word[7:0];
            o_pixel_stb <= 1'b1;
            state       <= ST_BYTE_HI;
          end
        end
        ST_BYTE_HI: begin
          if (byte_done) begin
            if (i_enable) begin
              o_tft_data <= pix_lo;
              state      <= ST_BYTE_LO;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_BYTE_LO: begin
          if (byte_done) begin
            pix_count <= pix_count + 24'd1;
            if (!i_enable || (pix_count + 24'd1 == frame_total)) state <= ST_DONE;
            else state <= ST_PIX_WAIT;
          end
        end
        ST_DONE: begin
          o_tft_cs_n   <= 1'b1;
          o_busy       <= 1'b0;
          o_frame_done <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_pixel_writer.sv
// Bench for tft_pixel_writer: default-timing instance (a_*) and a WR_LOW=3/WR_HIGH=1
// instance (b_*), driven by a randomized upstream and checked against a byte-level model.
module tb_tft_pixel_writer;
  import tft_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, a_start, b_start, i_pixel_rdy;
  logic [11:0] w_in, h_in;
  logic [7:0]  i_red, i_green, i_blue;
  logic        a_busy, a_fd, a_stb, a_cs_n, a_dc, a_wr_n;
  logic        b_busy, b_fd, b_stb, b_cs_n, b_dc, b_wr_n;
  logic [7:0]  a_data, b_data;
  tft_state_e  a_state, b_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0]  got_q[$];
  logic [8:0]  exp_q[$];
  logic [23:0] pix_q[$];
  int          fall_q[$];
  int          rise_q[$];
  int          stb_cnt, fd_cnt, fd_t, stable_err, cs_err;
  logic        cs_low_seen, busy_at1, end_cs, end_busy;

  always #5 clk = ~clk;

  tft_pixel_writer dut_a (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_start(a_start),
    .i_image_width(w_in), .i_image_height(h_in), .o_busy(a_busy), .o_frame_done(a_fd),
    .i_pixel_rdy(i_pixel_rdy), .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_pixel_stb(a_stb), .o_tft_cs_n(a_cs_n), .o_tft_dc(a_dc), .o_tft_wr_n(a_wr_n),
    .o_tft_data(a_data), .o_dbg_state(a_state)
  );

  tft_pixel_writer #(.WR_LOW_CYCLES(3), .WR_HIGH_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_start(b_start),
    .i_image_width(w_in), .i_image_height(h_in), .o_busy(b_busy), .o_frame_done(b_fd),
    .i_pixel_rdy(i_pixel_rdy), .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_pixel_stb(b_stb), .o_tft_cs_n(b_cs_n), .o_tft_dc(b_dc), .o_tft_wr_n(b_wr_n),
    .o_tft_data(b_data), .o_dbg_state(b_state)
  );

  // Reference: RGB565 by plain arithmetic on the 24-bit pixel value.
  function automatic int pix565(input logic [23:0] p);
    int v;
    v = int'(p);
    return ((v >> 19) & 31) * 2048 + ((v >> 10) & 63) * 32 + ((v >> 3) & 31);
  endfunction

  // Expected bus bytes {dc, data}: command, n_full whole pixels, optional lone high byte.
  task automatic build_exp(input int n_full, input bit extra_hi);
    int wd;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h2C});
    for (int i = 0; i < n_full; i++) begin
      wd = pix565(pix_q[i]);
      exp_q.push_back({1'b1, 8'(wd / 256)});
      exp_q.push_back({1'b1, 8'(wd % 256)});
    end
    if (extra_hi) begin
      wd = pix565(pix_q[n_full]);
      exp_q.push_back({1'b1, 8'(wd / 256)});
    end
  endtask

  task automatic fill_random(input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(24'($urandom_range(0, 24'hFFFFFF)));
  endtask

  // Runs one frame on instance sel (0 = a, 1 = b) while sampling its bus at negedge.
  task automatic run_frame(input bit sel, input int w, input int h, input int gap,
                           input int drop_at, input int max_cyc);
    int idx, gap_left, hcyc, hc, post;
    logic prev_wr, wr, dc, cs, stb, fd, busy, in_byte;
    logic [7:0] d;
    logic [8:0] lat;
    got_q.delete(); fall_q.delete(); rise_q.delete();
    stb_cnt = 0; fd_cnt = 0; fd_t = -1; stable_err = 0; cs_err = 0;
    cs_low_seen = 1'b0; busy_at1 = 1'b0; end_cs = 1'b0; end_busy = 1'b1;
    hcyc = sel ? 1 : 2;
    idx = 0; gap_left = 0; hc = 0; post = -1; prev_wr = 1'b1; in_byte = 1'b0; lat = '0;
    @(negedge clk);
    w_in = 12'(w); h_in = 12'(h); i_enable = 1'b1;
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    if (pix_q.size() > 0) begin
      i_pixel_rdy = 1'b1;
      {i_red, i_green, i_blue} = pix_q[0];
    end else begin
      i_pixel_rdy = 1'b0;
    end
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      a_start = 1'b0; b_start = 1'b0;
      if (c == 2) begin
        w_in = 12'($urandom_range(0, 4095));
        h_in = 12'($urandom_range(0, 4095));
      end
      wr = sel ? b_wr_n : a_wr_n;  dc = sel ? b_dc : a_dc;    d = sel ? b_data : a_data;
      cs = sel ? b_cs_n : a_cs_n;  stb = sel ? b_stb : a_stb; fd = sel ? b_fd : a_fd;
      busy = sel ? b_busy : a_busy;
      if (!cs) cs_low_seen = 1'b1;
      if (c == 1) busy_at1 = busy;
      if (prev_wr && !wr) begin
        got_q.push_back({dc, d}); fall_q.push_back(c);
        lat = {dc, d}; in_byte = 1'b1; hc = 0;
      end
      if (!prev_wr && wr) rise_q.push_back(c);
      if (in_byte) begin
        if ({dc, d} !== lat) stable_err++;
        if (cs) cs_err++;
        if (wr) begin
          hc++;
          if (hc == hcyc) in_byte = 1'b0;
        end
      end
      if (stb) begin
        stb_cnt++; idx++;
        if (drop_at >= 0 && stb_cnt == drop_at + 1) i_enable = 1'b0;
        if (idx < pix_q.size()) begin
          if (gap == 0) {i_red, i_green, i_blue} = pix_q[idx];
          else begin i_pixel_rdy = 1'b0; gap_left = gap; end
        end else begin
          i_pixel_rdy = 1'b0;
        end
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) begin
          i_pixel_rdy = 1'b1;
          {i_red, i_green, i_blue} = pix_q[idx];
        end
      end
      if (fd) begin
        fd_cnt++;
        if (fd_t < 0) fd_t = c;
        post = c + 3;
      end
      end_cs = cs; end_busy = busy; prev_wr = wr;
      if (post > 0 && c >= post) break;
    end
    i_pixel_rdy = 1'b0; i_enable = 1'b1;
  endtask

  task automatic test_reset;
    n_checks++; if (a_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", a_cs_n); else n_pass++;
    n_checks++; if (a_wr_n !== 1'b1) $display("FAIL reset_wr_n: got %b want 1", a_wr_n); else n_pass++;
    n_checks++; if (a_dc !== 1'b1) $display("FAIL reset_dc: got %b want 1", a_dc); else n_pass++;
    n_checks++; if (a_data !== 8'h00) $display("FAIL reset_data: got %h want 00", a_data); else n_pass++;
    n_checks++; if ({a_busy, a_fd, a_stb} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {a_busy, a_fd, a_stb}); else n_pass++;
    n_checks++; if ({b_cs_n, b_wr_n} !== 2'b11) $display("FAIL reset_b_bus: got %b want 11", {b_cs_n, b_wr_n}); else n_pass++;
  endtask

  task automatic test_known_pixels;
    pix_q.delete();
    pix_q.push_back(24'hFF8040);
    pix_q.push_back(24'h0000FF);
    build_exp(2, 1'b0);
    run_frame(1'b0, 2, 1, 1, -1, 300);
    n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL known_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL known_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (stb_cnt != 2) $display("FAIL known_stb: got %0d want 2", stb_cnt); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL known_frame_done: got %0d want 1", fd_cnt); else n_pass++;
    n_checks++; if (busy_at1 !== 1'b1) $display("FAIL known_busy: got %b want 1", busy_at1); else n_pass++;
    n_checks++; if ({end_cs, end_busy} !== 2'b10) $display("FAIL known_end: got cs/busy %b want 10", {end_cs, end_busy}); else n_pass++;
    n_checks++; if (stable_err + cs_err != 0) $display("FAIL known_stable: got %0d want 0", stable_err + cs_err); else n_pass++;
  endtask

  task automatic test_wr_timing;
    int bad_low;
    fill_random(1);
    build_exp(1, 1'b0);
    run_frame(1'b1, 1, 1, 0, -1, 200);
    bad_low = 0;
    for (int i = 0; i < fall_q.size() && i < rise_q.size(); i++)
      if (rise_q[i] - fall_q[i] != 3) bad_low++;
    n_checks++; if (fall_q.size() != 3) $display("FAIL timing_falls: got %0d want 3", fall_q.size()); else n_pass++;
    n_checks++; if (rise_q.size() != 3 || bad_low != 0) $display("FAIL timing_low3: got %0d bad of %0d want 0 of 3", bad_low, rise_q.size()); else n_pass++;
    if (fall_q.size() >= 3) begin
      n_checks++; if (fall_q[1] - fall_q[0] != 5) $display("FAIL timing_cmd_gap: got %0d want 5", fall_q[1] - fall_q[0]); else n_pass++;
      n_checks++; if (fall_q[2] - fall_q[1] != 4) $display("FAIL timing_byte_period: got %0d want 4", fall_q[2] - fall_q[1]); else n_pass++;
    end
    n_checks++; if (stb_cnt != 1) $display("FAIL timing_stb: got %0d want 1", stb_cnt); else n_pass++;
    n_checks++; if (got_q != exp_q) $display("FAIL timing_bytes: got %0d bytes want %0d", got_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (stable_err + cs_err != 0) $display("FAIL timing_stable: got %0d want 0", stable_err + cs_err); else n_pass++;
  endtask

  task automatic test_zero_size;
    pix_q.delete();
    run_frame(1'b0, 0, 5, 0, -1, 40);
    n_checks++; if (fall_q.size() != 0) $display("FAIL zero_falls: got %0d want 0", fall_q.size()); else n_pass++;
    n_checks++; if (cs_low_seen !== 1'b0) $display("FAIL zero_cs: got %b want 0", cs_low_seen); else n_pass++;
    n_checks++; if (fd_t != 2) $display("FAIL zero_fd_time: got %0d want 2", fd_t); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL zero_fd_count: got %0d want 1", fd_cnt); else n_pass++;
    n_checks++; if (stb_cnt != 0) $display("FAIL zero_stb: got %0d want 0", stb_cnt); else n_pass++;
  endtask

  task automatic test_random_frames;
    int w, h, gap, bad_low;
    for (int f = 0; f < 5; f++) begin
      w = $urandom_range(1, 3); h = $urandom_range(1, 3); gap = $urandom_range(0, 3);
      fill_random(w * h);
      build_exp(w * h, 1'b0);
      run_frame(1'b0, w, h, gap, -1, 1000);
      bad_low = 0;
      for (int i = 0; i < fall_q.size() && i < rise_q.size(); i++)
        if (rise_q[i] - fall_q[i] != 2) bad_low++;
      n_checks++; if (got_q != exp_q) $display("FAIL rand%0d_bytes: got %0d bytes want %0d (w=%0d h=%0d)", f, got_q.size(), exp_q.size(), w, h); else n_pass++;
      n_checks++; if (stb_cnt != w * h) $display("FAIL rand%0d_stb: got %0d want %0d", f, stb_cnt, w * h); else n_pass++;
      n_checks++; if (fd_cnt != 1) $display("FAIL rand%0d_fd: got %0d want 1", f, fd_cnt); else n_pass++;
      n_checks++; if (bad_low + stable_err + cs_err != 0) $display("FAIL rand%0d_strobe: got %0d errors want 0", f, bad_low + stable_err + cs_err); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    fill_random(4);
    build_exp(4, 1'b0);
    run_frame(1'b0, 4, 1, 0, -1, 300);
    n_checks++; if (got_q != exp_q) $display("FAIL b2b_bytes: got %0d bytes want %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (fall_q.size() >= 6) begin
      n_checks++; if (fall_q[3] - fall_q[1] != 9) $display("FAIL b2b_period1: got %0d want 9", fall_q[3] - fall_q[1]); else n_pass++;
      n_checks++; if (fall_q[5] - fall_q[3] != 9) $display("FAIL b2b_period2: got %0d want 9", fall_q[5] - fall_q[3]); else n_pass++;
    end
  endtask

  task automatic test_starvation;
    fill_random(3);
    build_exp(3, 1'b0);
    run_frame(1'b0, 3, 1, 20, -1, 400);
    n_checks++; if (got_q != exp_q) $display("FAIL starve_bytes: got %0d bytes want %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (fall_q.size() >= 4) begin
      n_checks++; if (fall_q[3] - fall_q[1] != 21) $display("FAIL starve_gap: got %0d want 21", fall_q[3] - fall_q[1]); else n_pass++;
    end
    n_checks++; if (stable_err + cs_err != 0) $display("FAIL starve_stable: got %0d want 0", stable_err + cs_err); else n_pass++;
    n_checks++; if (stb_cnt != 3) $display("FAIL starve_stb: got %0d want 3", stb_cnt); else n_pass++;
  endtask

  task automatic test_enable_drop;
    fill_random(10);
    build_exp(2, 1'b1);
    run_frame(1'b0, 10, 1, 0, 2, 400);
    n_checks++; if (got_q != exp_q) $display("FAIL drop_bytes: got %0d bytes want %0d", got_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (stb_cnt != 3) $display("FAIL drop_stb: got %0d want 3", stb_cnt); else n_pass++;
    n_checks++; if (fd_cnt != 1) $display("FAIL drop_fd: got %0d want 1", fd_cnt); else n_pass++;
    n_checks++; if ({end_cs, end_busy} !== 2'b10) $display("FAIL drop_end: got cs/busy %b want 10", {end_cs, end_busy}); else n_pass++;
  endtask

  task automatic test_reset_mid_byte;
    bit found;
    int fd_seen;
    found = 1'b0; fd_seen = 0;
    @(negedge clk);
    w_in = 12'd1; h_in = 12'd1; i_enable = 1'b1; a_start = 1'b1;
    i_pixel_rdy = 1'b1; {i_red, i_green, i_blue} = 24'($urandom_range(0, 24'hFFFFFF));
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (a_state == ST_BYTE_HI) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rst_mid_reach: got no BYTE_HI want BYTE_HI"); else n_pass++;
    rst = 1'b1; i_pixel_rdy = 1'b0;
    @(negedge clk);
    n_checks++; if ({a_cs_n, a_wr_n, a_dc} !== 3'b111) $display("FAIL rst_mid_bus: got %b want 111", {a_cs_n, a_wr_n, a_dc}); else n_pass++;
    n_checks++; if ({a_data, a_busy, a_fd} !== 10'd0) $display("FAIL rst_mid_regs: got %h want 0", {a_data, a_busy, a_fd}); else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (a_fd) fd_seen++;
    end
    n_checks++; if (fd_seen != 0) $display("FAIL rst_mid_fd: got %0d want 0", fd_seen); else n_pass++;
    n_checks++; if (a_state != ST_IDLE) $display("FAIL rst_mid_state: got %0d want %0d", a_state, ST_IDLE); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b1; a_start = 1'b0; b_start = 1'b0; i_pixel_rdy = 1'b0;
    w_in = '0; h_in = '0; i_red = '0; i_green = '0; i_blue = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_known_pixels;
    test_wr_timing;
    test_zero_size;
    test_random_frames;
    test_back_to_back;
    test_starvation;
    test_enable_drop;
    test_reset_mid_byte;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
